// File: rtl/i2c_target_regif.sv
// I2C target that converts bus transfers into single-cycle register-file strobes.
// SCL/SDA are synchronized and glitch-filtered; SDA is only ever pulled low.
module i2c_target_regif #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       I2C_SCL_IN,
    input  logic       I2C_SDA_IN,
    output logic       I2C_SDA_OE,
    output logic       REG_WE,
    output logic       REG_RE,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    input  logic [7:0] REG_RDATA,
    output logic       BUSY
);
    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic [3:0] scl_cnt_q, sda_cnt_q;
    logic       scl_f_q, sda_f_q, scl_fd_q, sda_fd_q;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic       we_q, we_d;
    logic       re_q, re_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       busy_q, busy_d;
    logic [1:0] load_q, load_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    // A filtered level flips only after FILT_LEN consecutive differing samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_fd_q   <= 1'b1;
            sda_fd_q   <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], I2C_SCL_IN};
            sda_sync_q <= {sda_sync_q[0], I2C_SDA_IN};
            scl_fd_q   <= scl_f_q;
            sda_fd_q   <= sda_f_q;
            if (scl_sync_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FILT_MAX) begin
                scl_f_q   <= scl_sync_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 4'd1;
            end
            if (sda_sync_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FILT_MAX) begin
                sda_f_q   <= sda_sync_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 4'd1;
            end
        end
    end

    assign scl_rise  = scl_f_q & ~scl_fd_q;
    assign scl_fall  = ~scl_f_q & scl_fd_q;
    assign start_det = scl_f_q & scl_fd_q & sda_fd_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_fd_q & ~sda_fd_q & sda_f_q;
    assign byte_in   = {shift_q[6:0], sda_f_q};

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        rw_d     = rw_q;
        oe_d     = oe_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        load_d   = {load_q[0], 1'b0};
        // Read data arrives two CLKs after the strobe; its MSB goes out at once.
        if (load_q[1]) begin
            shift_d = REG_RDATA;
            oe_d    = ~REG_RDATA[7];
        end
        if (stop_det) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            oe_d     = 1'b0;
            bitcnt_d = '0;
            load_d   = '0;
        end else if (start_det) begin
            state_d  = ADDR;
            oe_d     = 1'b0;
            bitcnt_d = '0;
            load_d   = '0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bitcnt_q != 4'd8) begin
                        shift_d  = byte_in;
                        bitcnt_d = bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd7) begin
                            if (state_q == ADDR) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    busy_d = 1'b1;
                                    rw_d   = byte_in[0];
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == PTR) begin
                                addr_d = byte_in;
                            end else begin
                                wdata_d = byte_in;
                                we_d    = 1'b1;
                            end
                        end
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        oe_d     = 1'b1;
                        bitcnt_d = '0;
                        if (state_q == ADDR)     state_d = ADDR_ACK;
                        else if (state_q == PTR) state_d = PTR_ACK;
                        else                     state_d = WDATA_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        oe_d = 1'b0;
                        if (rw_q) begin
                            re_d    = 1'b1;
                            load_d  = 2'b01;
                            state_d = RDATA;
                        end else begin
                            state_d = PTR;
                        end
                    end
                end
                PTR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        state_d = WDATA;
                    end
                end
                WDATA_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        addr_d  = addr_q + 8'd1;
                        state_d = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        oe_d     = 1'b0;
                        bitcnt_d = '0;
                        state_d  = RDATA_ACK;
                    end else if (scl_fall && bitcnt_q != 4'd0) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end
                end
                RDATA_ACK: begin
                    // bitcnt doubles as the "controller acknowledged" flag here.
                    if (scl_rise) begin
                        if (!sda_f_q) begin
                            addr_d   = addr_q + 8'd1;
                            bitcnt_d = 4'd1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall && bitcnt_q == 4'd1) begin
                        re_d     = 1'b1;
                        load_d   = 2'b01;
                        bitcnt_d = '0;
                        state_d  = RDATA;
                    end
                end
                IGNORE:  oe_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            rw_q     <= 1'b0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            load_q   <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            rw_q     <= rw_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            re_q     <= re_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            load_q   <= load_d;
        end
    end

    assign I2C_SDA_OE = oe_q;
    assign REG_WE     = we_q;
    assign REG_RE     = re_q;
    assign REG_ADDR   = addr_q;
    assign REG_WDATA  = wdata_q;
    assign BUSY       = busy_q;

endmodule
